mean_window_monitor: RTL and testbench
======================================

Name: mean_window_monitor

Overview:
- Downstream consumer of the mean-computation unit.
- Detects each completed computation (rising edge of the unit's done) and captures the 8-bit mean into a circular window of the last 2^DEPTH_LOG2 results.
- Publishes a moving average of those means, a sample count and a sticky threshold alarm.
- Sits between the mean unit and the system's status/readout logic.

Parameters:
- WIDTH, 8, bit width of mean samples and of avg.
- DEPTH_LOG2, 2, log2 of window depth; window holds 4 entries by default.
- THRESH, 200, alarm threshold compared against avg (unsigned, strict greater-than).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; rst=0 clears all state immediately.
- done  input  1  done from the mean unit; may be a 1-cycle pulse or held high for many cycles.
- mean  input  WIDTH  mean result; valid whenever done is high.
- clear  input  1  synchronous flush of window, count and alarm.
- avg  output  WIDTH  moving average of the window: sum >> DEPTH_LOG2.
- avg_valid  output  1  one-cycle pulse when avg updates with a full window.
- count  output  DEPTH_LOG2+1  number of samples in the window; saturates at 2^DEPTH_LOG2.
- alarm  output  1  sticky flag, set when an updated avg > THRESH.
- min_mean  output  WIDTH  smallest accepted mean (optional feature).
- max_mean  output  WIDTH  largest accepted mean (optional feature).

Behaviour:
- Reset values (rst=0): all buffer entries 0, write pointer 0, sum 0, count 0, avg 0, avg_valid 0, alarm 0, min_mean 0, max_mean 0, done_d 0. Reset mid-fill discards every stored sample.
- Edge detect: done_d is done registered. A sample is accepted on an edge where done=1 and done_d=0. A done held high for N cycles yields exactly one sample.
- Accept edge (stage 1):
  - buf[wptr] <= mean
  - sum <= sum + mean - buf[wptr]; sum is WIDTH+DEPTH_LOG2 bits and cannot overflow.
  - wptr increments and wraps 2^DEPTH_LOG2-1 -> 0.
  - count increments, saturating at 2^DEPTH_LOG2.
- Following edge (stage 2):
  - avg <= sum >> DEPTH_LOG2 (truncating).
  - avg_valid <= 1 only if count == 2^DEPTH_LOG2; otherwise 0.
  - alarm set if avg_valid is asserted and the new avg > THRESH.
- Latency: done rising edge sampled at edge k -> avg/avg_valid visible after edge k+1. avg_valid is 0 in every cycle without a stage-2 update.
- State machine phase, derived from count:
  - EMPTY: count=0.
  - FILLING: 0<count<2^DEPTH_LOG2.
  - FULL: count=2^DEPTH_LOG2.
  - Transitions: EMPTY->FILLING->FULL on accepts; any state -> EMPTY on clear or reset. FULL remains FULL on accepts.
- Before FULL, avg still tracks sum>>DEPTH_LOG2, so it is a partial sum scaled by the full depth. avg_valid stays 0.
- clear (synchronous, edge where clear=1):
  - Buffer, sum, wptr, count, alarm, min/max return to reset values.
  - avg_valid forced 0; avg holds its last value.
- clear and accept on the same edge: clear wins and the sample is discarded. done_d still updates, so the held done does not re-trigger.
- A done pulse arriving in the stage-2 cycle is accepted normally (back-to-back accepts every 2 cycles minimum, given edge detect). Stage 2 always uses the sum from the immediately preceding accept.
- alarm stays 1 until clear or reset, even if avg later falls.

Optional Feature:
- Macro MEAN_WINDOW_MINMAX_EN.
- Defined: min_mean/max_mean track the extremes of accepted samples since last reset/clear.
  - On first accept after reset/clear, both load mean.
  - Afterwards they update on each accept with unsigned compare, in the same edge as stage 1.
- Undefined: the tracking registers are not built; min_mean and max_mean are tied to 0.

Test Plan (defaults WIDTH=8, DEPTH_LOG2=2, THRESH=200):
- Release rst, four done pulses with mean=25 -> count 1,2,3,4. avg_valid pulses once, one cycle after the 4th accept. avg=25, alarm=0.
- Continue from full window, one pulse with mean=100 -> sum=175, avg=43, avg_valid pulses, count stays 4.
- done held high 6 cycles with mean=60 -> exactly one sample accepted (count +1); done drop and re-raise -> second sample.
- Four pulses of mean=250 -> avg=250, alarm=1. Then four pulses of mean=10 -> avg=10, alarm still 1. Assert clear -> alarm=0, count=0.
- clear and a done rising edge on the same edge with mean=99 -> count=0, sum=0, no avg_valid. With MEAN_WINDOW_MINMAX_EN: min_mean=max_mean=0.
- Four pulses of 255 -> avg=255 (sum 1020, no overflow). Drop rst mid-sequence after 2 samples -> all outputs 0 immediately, without waiting for a clock edge. With MEAN_WINDOW_MINMAX_EN, samples 7,3,9 -> min_mean=3, max_mean=9.

Source files
------------

// File: rtl/mean_window_monitor.sv
// mean_window_monitor
//
// Watches the done/mean output of the mean-computation unit. Every rising
// edge of done captures one mean sample into a circular window of the last
// 2^DEPTH_LOG2 results. The block publishes the windowed moving average,
// the number of samples held, and a sticky alarm for averages above THRESH.
//
// Optional feature, macro MEAN_WINDOW_MINMAX_EN: when defined, min_mean and
// max_mean track the smallest and largest accepted sample since the last
// reset/clear. When undefined, those registers are not built and both
// outputs are tied to 0.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst        asynchronous active-low reset
//   done       completion flag from the mean unit (pulse or held level)
//   mean       mean result, qualified by done
//   clear      synchronous flush of window, count, alarm and min/max
//   avg        window sum >> DEPTH_LOG2 (truncating)
//   avg_valid  one-cycle pulse when avg updates from a full window
//   count      samples in the window, saturating at 2^DEPTH_LOG2
//   alarm      sticky, set when a valid updated avg exceeds THRESH
//   min_mean   smallest accepted sample (0 when the feature is off)
//   max_mean   largest accepted sample (0 when the feature is off)
//   phase      debug view of the fill state: 0 EMPTY, 1 FILLING, 2 FULL
//
// Handshake: done/mean carry no ready; the monitor is always able to take a
// sample. A sample is accepted on the clock edge where done=1 and the
// registered done_d=0, so a done held high for many cycles yields exactly
// one sample, and mean is only looked at on that edge.

module mean_window_monitor #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2,
  parameter int THRESH     = 200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  done,
  input  logic [WIDTH-1:0]      mean,
  input  logic                  clear,
  output logic [WIDTH-1:0]      avg,
  output logic                  avg_valid,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  alarm,
  output logic [WIDTH-1:0]      min_mean,
  output logic [WIDTH-1:0]      max_mean,
  output logic [1:0]            phase
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int SW    = WIDTH + DEPTH_LOG2;

  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] LAST_CNT = FULL_CNT - 1'b1;
  localparam logic [WIDTH-1:0]    THRESH_W = WIDTH'(THRESH);

  typedef enum logic [1:0] {
    PH_EMPTY   = 2'd0,
    PH_FILLING = 2'd1,
    PH_FULL    = 2'd2
  } phase_t;

  logic [WIDTH-1:0]      win_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [SW-1:0]         sum;
  logic                  done_d;
  logic                  stage2;
  logic                  accept;
  logic                  full;
  logic [SW-1:0]         sum_next;
  logic [WIDTH-1:0]      avg_next;
  phase_t                state;
  phase_t                state_next;

  assign accept = done & ~done_d;
  assign full   = (count == FULL_CNT);

  // The slot being overwritten is always part of sum (empty slots hold 0),
  // so the subtraction never underflows and SW bits cannot overflow.
  assign sum_next = sum + SW'(mean) - SW'(win_mem[wptr]);
  assign avg_next = sum[SW-1:DEPTH_LOG2];

  // Stage 1 (accept edge) updates the window; stage 2 (next edge) publishes
  // the average of the sum stage 1 produced. A new accept may land on the
  // stage-2 edge: stage 2 then reads the sum/count from the previous accept
  // while stage 1 updates them underneath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) win_mem[i] <= '0;
      wptr      <= '0;
      sum       <= '0;
      count     <= '0;
      avg       <= '0;
      avg_valid <= 1'b0;
      alarm     <= 1'b0;
      done_d    <= 1'b0;
      stage2    <= 1'b0;
    end else begin
      // done_d tracks done even during clear so a held done cannot re-fire.
      done_d <= done;
      if (clear) begin
        for (int i = 0; i < DEPTH; i++) win_mem[i] <= '0;
        wptr      <= '0;
        sum       <= '0;
        count     <= '0;
        alarm     <= 1'b0;
        avg_valid <= 1'b0;
        stage2    <= 1'b0;
        // avg deliberately keeps its last value.
      end else begin
        stage2    <= accept;
        avg_valid <= stage2 && full;
        if (accept) begin
          win_mem[wptr] <= mean;
          sum           <= sum_next;
          wptr          <= wptr + 1'b1;
          if (!full) count <= count + 1'b1;
        end
        if (stage2) begin
          avg <= avg_next;
          if (full && (avg_next > THRESH_W)) alarm <= 1'b1;
        end
      end
    end
  end

  // Fill-phase tracker, kept in step with count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= PH_EMPTY;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = PH_EMPTY;
    end else if (accept) begin
      case (state)
        PH_EMPTY:   state_next = (count == LAST_CNT) ? PH_FULL : PH_FILLING;
        PH_FILLING: state_next = (count == LAST_CNT) ? PH_FULL : PH_FILLING;
        PH_FULL:    state_next = PH_FULL;
        default:    state_next = PH_EMPTY;
      endcase
    end
  end

  assign phase = state;

`ifdef MEAN_WINDOW_MINMAX_EN
  // count==0 marks the first accept after reset/clear: load both extremes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min_mean <= '0;
      max_mean <= '0;
    end else if (clear) begin
      min_mean <= '0;
      max_mean <= '0;
    end else if (accept) begin
      if (count == '0) begin
        min_mean <= mean;
        max_mean <= mean;
      end else begin
        if (mean < min_mean) min_mean <= mean;
        if (mean > max_mean) max_mean <= mean;
      end
    end
  end
`else
  assign min_mean = '0;
  assign max_mean = '0;
`endif

endmodule

// File: tb/tb_mean_window_monitor.sv
// tb_mean_window_monitor
//
// Directed bench for mean_window_monitor at default parameters
// (WIDTH=8, DEPTH_LOG2=2, THRESH=200). Expected averages for every
// avg_valid pulse are hand-computed and queued in exp_q; a negedge monitor
// pops them when avg_valid is seen and flags any unexpected pulse.
// Inputs change on the falling edge, outputs are sampled on the falling edge.

module tb_mean_window_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       done;
  logic [7:0] mean;
  logic       clear;
  logic [7:0] avg;
  logic       avg_valid;
  logic [2:0] count;
  logic       alarm;
  logic [7:0] min_mean;
  logic [7:0] max_mean;
  logic [1:0] phase;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  mean_window_monitor #(
    .WIDTH(8),
    .DEPTH_LOG2(2),
    .THRESH(200)
  ) dut (
    .clk(clk),
    .rst(rst),
    .done(done),
    .mean(mean),
    .clear(clear),
    .avg(avg),
    .avg_valid(avg_valid),
    .count(count),
    .alarm(alarm),
    .min_mean(min_mean),
    .max_mean(max_mean),
    .phase(phase)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string p);
    check({p, "_avg"},       32'(avg),       0);
    check({p, "_avg_valid"}, 32'(avg_valid), 0);
    check({p, "_count"},     32'(count),     0);
    check({p, "_alarm"},     32'(alarm),     0);
    check({p, "_min"},       32'(min_mean),  0);
    check({p, "_max"},       32'(max_mean),  0);
    check({p, "_phase"},     32'(phase),     0);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst === 1'b1 && avg_valid === 1'b1) begin
      if (exp_q.size() == 0) check("avg_valid_unexpected", 1, 0);
      else                   check("avg_at_valid", 32'(avg), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- drivers ----------------
  task automatic send(input logic [7:0] m);
    @(negedge clk);
    done = 1'b1;
    mean = m;
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic hold(input logic [7:0] m, input int n);
    @(negedge clk);
    done = 1'b1;
    mean = m;
    repeat (n) @(negedge clk);
    done = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst   = 1'b0;
    done  = 1'b0;
    clear = 1'b0;
    mean  = 8'd0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;

    // Fill with 25s; partial averages are scaled by full depth.
    send(8'd25);  check("fill1_count", 32'(count), 1); check("fill1_phase", 32'(phase), 1);
    step();       check("fill1_avg", 32'(avg), 6);     check("fill1_valid", 32'(avg_valid), 0);
    send(8'd25);  check("fill2_count", 32'(count), 2);
    step();       check("fill2_avg", 32'(avg), 12);
    send(8'd25);  check("fill3_count", 32'(count), 3);
    exp_q.push_back(8'd25);
    send(8'd25);  check("fill4_count", 32'(count), 4); check("fill4_phase", 32'(phase), 2);
    check("fill4_latency_avg", 32'(avg), 18);          check("fill4_latency_valid", 32'(avg_valid), 0);
    step();       check("full_valid", 32'(avg_valid), 1); check("full_avg", 32'(avg), 25);
    step();       check("valid_one_cycle", 32'(avg_valid), 0); check("full_alarm", 32'(alarm), 0);

    // Slide: 100 replaces a 25 -> sum 175, avg 43.
    exp_q.push_back(8'd43);
    send(8'd100); check("slide_count", 32'(count), 4);
    step();       check("slide_avg", 32'(avg), 43);

    // Held done: one sample only. Then drop and re-raise.
    exp_q.push_back(8'd52);
    hold(8'd60, 6); check("held_avg", 32'(avg), 52);
    step();
    exp_q.push_back(8'd61);
    send(8'd60);
    step();       check("reraise_avg", 32'(avg), 61);

    // 250s: averages 117,155,202,250; alarm first set at 202.
    exp_q.push_back(8'd117); exp_q.push_back(8'd155);
    exp_q.push_back(8'd202); exp_q.push_back(8'd250);
    send(8'd250); send(8'd250);
    step();       check("alarm_below", 32'(alarm), 0);
    send(8'd250);
    step();       check("alarm_set", 32'(alarm), 1);
    send(8'd250);
    step();       check("hi_avg", 32'(avg), 250);

    // 10s: averages 190,130,70,10; alarm stays sticky.
    exp_q.push_back(8'd190); exp_q.push_back(8'd130);
    exp_q.push_back(8'd70);  exp_q.push_back(8'd10);
    repeat (4) send(8'd10);
    step();       check("lo_avg", 32'(avg), 10); check("alarm_sticky", 32'(alarm), 1);

    do_clear();
    check("clr_alarm", 32'(alarm), 0);
    check("clr_count", 32'(count), 0);
    check("clr_phase", 32'(phase), 0);
    check("clr_avg_hold", 32'(avg), 10);
    check("clr_valid", 32'(avg_valid), 0);

    // Exactly THRESH does not raise the alarm.
    exp_q.push_back(8'd200);
    repeat (4) send(8'd200);
    step();       check("thresh_avg", 32'(avg), 200); check("thresh_alarm", 32'(alarm), 0);

    // clear and accept on the same edge: sample discarded, no re-trigger.
    @(negedge clk);
    clear = 1'b1;
    done  = 1'b1;
    mean  = 8'd99;
    @(negedge clk);
    clear = 1'b0;
    repeat (2) @(negedge clk);
    done = 1'b0;
    check("clracc_count", 32'(count), 0);
    check("clracc_min", 32'(min_mean), 0);
    check("clracc_max", 32'(max_mean), 0);
    check("clracc_avg_hold", 32'(avg), 200);
    step();
    check("clracc_count2", 32'(count), 0);

    // All-255 window: sum 1020, avg 255 without overflow.
    exp_q.push_back(8'd255);
    repeat (4) send(8'd255);
    step();
    check("max_avg", 32'(avg), 255);
    check("max_count", 32'(count), 4);
    check("max_alarm", 32'(alarm), 1);

    // Async reset mid-fill, between clock edges.
    do_clear();
    send(8'd7);
    send(8'd3);
    step();
    check("midfill_avg", 32'(avg), 2);
    check("midfill_count", 32'(count), 2);
    #2;
    rst = 1'b0;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    rst = 1'b1;

    // Extremes tracking, then a held done bumps count 3 -> 4.
    send(8'd7); send(8'd3); send(8'd9);
    step();
    check("mm_count", 32'(count), 3);
`ifdef MEAN_WINDOW_MINMAX_EN
    check("mm_min", 32'(min_mean), 3);
    check("mm_max", 32'(max_mean), 9);
`else
    check("mm_min_off", 32'(min_mean), 0);
    check("mm_max_off", 32'(max_mean), 0);
`endif
    exp_q.push_back(8'd19);
    hold(8'd60, 4);
    step();
    check("held_count_inc", 32'(count), 4);
    step();
    check("exp_q_drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
